i2c_target_rx: RTL and testbench

I2C target (responder) that sits on the same two-wire bus as the team's I2C master and decodes its transactions. It synchronises the open-drain SCL/SDA pins, detects START/STOP, matches a 7-bit address and ACKs it. Write bytes are presented to the fabric as rx_data/rx_valid strobes. Read bytes are fetched from the fabric through an rd_req/rd_data handshake and shifted out MSB first. clk must run at least 8x the SCL rate.

---
 rtl/i2c_target_rx.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// I2C target receiver/transmitter: synchronises SCL/SDA, detects START/STOP,
// ACKs TARGET_ADDR, delivers write bytes and serves read bytes via rd_req/rd_data.
module i2c_target_rx #(
    parameter logic [6:0]  TARGET_ADDR = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic [7:0] byte_cnt,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_c, stop_c;

    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       done, done_n;
    logic       rw, rw_n;
    logic       sda_oe_n, rx_valid_n, rd_req_n, start_n, stop_n;
    logic [7:0] rx_data_n, byte_cnt_n, byte_inc;

    // Pins idle high, so the synchroniser resets high to avoid phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_inc = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rd_req    <= 1'b0;
            byte_cnt  <= '0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            done      <= done_n;
            rw        <= rw_n;
            sda_oe    <= sda_oe_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            rd_req    <= rd_req_n;
            byte_cnt  <= byte_cnt_n;
            start_det <= start_n;
            stop_det  <= stop_n;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        done_n     = done;
        rw_n       = rw;
        sda_oe_n   = sda_oe;
        rx_data_n  = rx_data;
        byte_cnt_n = byte_cnt;
        rx_valid_n = 1'b0;
        rd_req_n   = 1'b0;
        start_n    = 1'b0;
        stop_n     = 1'b0;

        if (stop_c) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            done_n   = 1'b0;
            stop_n   = 1'b1;
        end else if (start_c) begin
            state_n    = ADDR;
            bit_cnt_n  = '0;
            done_n     = 1'b0;
            byte_cnt_n = '0;
            sda_oe_n   = 1'b0;
            start_n    = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // shift[6:0] here becomes shift[7:1] once the R/W bit lands
                            if (shift[6:0] == TARGET_ADDR && TARGET_ADDR != 7'd0) begin
                                rw_n     = sda_s;
                                rd_req_n = sda_s;
                                done_n   = 1'b1;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && done) begin
                        done_n   = 1'b0;
                        sda_oe_n = 1'b1;
                        state_n  = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (rw) begin
                            shift_n  = rd_data;
                            sda_oe_n = ~rd_data[7];
                            state_n  = RDATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = {shift[6:0], sda_s};
                            rx_valid_n = 1'b1;
                            byte_cnt_n = byte_inc;
                            done_n     = 1'b1;
                        end
                    end else if (scl_fall && done) begin
                        done_n   = 1'b0;
                        sda_oe_n = 1'b1;
                        state_n  = WACK;
                    end
                end
                WACK: begin
                    if (scl_fall) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            done_n = 1'b1;
                    end else if (scl_fall) begin
                        if (done) begin
                            done_n   = 1'b0;
                            sda_oe_n = 1'b0;
                            state_n  = RACK;
                        end else begin
                            shift_n  = {shift[6:0], 1'b0};
                            sda_oe_n = ~shift[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            rd_req_n   = 1'b1;
                            byte_cnt_n = byte_inc;
                            done_n     = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end else if (scl_fall && done) begin
                        done_n    = 1'b0;
                        bit_cnt_n = '0;
                        shift_n   = rd_data;
                        sda_oe_n  = ~rd_data[7];
                        state_n   = RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bus-master driven bench: expected write bytes and read data go into queues,
// monitors compare them against rx_valid/rd_req activity.
module tb_i2c_target_rx;

    localparam logic [6:0] ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, rx_valid, rd_req, busy, start_det, stop_det;
    logic [7:0] rx_data, byte_cnt, rd_data;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_rx #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rd_req(rd_req), .rd_data(rd_data),
        .byte_cnt(byte_cnt), .busy(busy), .start_det(start_det), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int starts = 0, stops = 0, exp_starts = 0, exp_stops = 0;
    int rdreqs = 0, exp_rdreqs = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] rd_src[$];
    logic [7:0] rd_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: pops expectations whenever the DUT presents a strobe
    always @(negedge clk) begin
        if (rst) begin
            rd_data = '0;
        end else begin
            if (rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_spurious: got rx_valid with 0x%0h expected no write byte", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_rx.pop_front());
                end
            end
            if (rd_req === 1'b1) begin
                rdreqs++;
                if (rd_src.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_req_spurious: got rd_req expected none");
                end else begin
                    rd_data = rd_src.pop_front();
                end
            end
            if (start_det === 1'b1) starts++;
            if (stop_det === 1'b1) stops++;
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, input bit glitch, output logic r);
        wclk(4);
        if (glitch) begin
            for (int g = 0; g < 3; g++) begin
                sda_m = ~sda_m;
                wclk(1);
            end
        end
        sda_m = b;
        wclk(4);
        scl = 1'b1;
        wclk(4);
        r = sda_bus;
        wclk(4);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        if (scl == 1'b0) begin
            wclk(4);
            sda_m = 1'b1;
            wclk(8);
            scl = 1'b1;
            wclk(4);
        end
        sda_m = 1'b0;
        exp_starts++;
        wclk(4);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        wclk(4);
        sda_m = 1'b0;
        wclk(4);
        scl = 1'b1;
        wclk(4);
        sda_m = 1'b1;
        exp_stops++;
        wclk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack_level, input bit glitch, input bit expect_rx);
        logic r;
        if (expect_rx) exp_rx.push_back(b);
        for (int i = 7; i >= 0; i--) clock_bit(b[i], glitch && (i == 4), r);
        clock_bit(1'b1, 1'b0, r);
        check("ack_level", r, exp_ack_level);
    endtask

    task automatic recv_byte(input logic nack);
        logic [7:0] v;
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, r);
            v[i] = r;
        end
        check("rd_byte", v, rd_exp.pop_front());
        clock_bit(nack, 1'b0, r);
    endtask

    // Reference model: a hit is an exact, non-zero address match; every hit write
    // byte is ACKed and counted, read bytes count only when the master ACKs them.
    task automatic txn(input logic [6:0] a, input logic rw, input int n, input bit end_stop,
                       input logic [7:0] d0, input logic [7:0] d1);
        bit hit;
        int cnt, base;
        logic [7:0] b;
        hit = (a == ADDR) && (a != 7'd0);
        cnt = 0;
        start_cond();
        if (hit && rw) begin
            for (int i = 0; i < n; i++) begin
                b = (i == 0) ? d0 : (i == 1) ? d1 : 8'($urandom);
                rd_src.push_back(b);
                rd_exp.push_back(b);
            end
            exp_rdreqs += n;
        end
        base = rdreqs;
        send_byte({a, rw}, hit ? 1'b0 : 1'b1, 1'b0, 1'b0);
        if (hit && rw) begin
            check("rd_req_on_addr", rdreqs, base + 1);
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1);
                if (i < n - 1) cnt++;
            end
        end else begin
            for (int i = 0; i < n; i++) begin
                b = (i == 0) ? d0 : (i == 1) ? d1 : 8'($urandom);
                send_byte(b, hit ? 1'b0 : 1'b1, 1'b0, hit);
                if (hit) cnt = (cnt < 255) ? cnt + 1 : 255;
            end
        end
        check("byte_cnt", byte_cnt, cnt);
        check("busy_active", busy, 1);
        if (end_stop) begin
            stop_cond();
            check("busy_idle", busy, 0);
            check("start_count", starts, exp_starts);
            check("stop_count", stops, exp_stops);
        end
    endtask

    initial begin
        logic r;
        logic [6:0] a;

        wclk(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rd_req", rd_req, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_start_det", start_det, 0);
        check("rst_stop_det", stop_det, 0);
        rst = 1'b0;
        wclk(8);

        txn(ADDR, 1'b0, 2, 1'b1, 8'hA5, 8'h3C);
        txn(7'h43, 1'b0, 1, 1'b1, 8'hFF, 8'h00);
        txn(ADDR, 1'b1, 2, 1'b1, 8'h96, 8'h0F);

        // Repeated START in the middle of a data byte
        start_cond();
        send_byte({ADDR, 1'b0}, 1'b0, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0, 1'b1);
        clock_bit(1'b0, 1'b0, r);
        clock_bit(1'b1, 1'b0, r);
        clock_bit(1'b0, 1'b0, r);
        start_cond();
        wclk(2);
        check("byte_cnt_after_rstart", byte_cnt, 0);
        send_byte({ADDR, 1'b0}, 1'b0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 1'b1);
        check("byte_cnt_after_rstart_byte", byte_cnt, 1);
        stop_cond();
        check("start_count_rstart", starts, exp_starts);

        // Reset while the target holds SDA low for a write ACK
        start_cond();
        send_byte({ADDR, 1'b0}, 1'b0, 1'b0, 1'b0);
        exp_rx.push_back(8'h5A);
        for (int i = 7; i >= 0; i--) clock_bit(1'($unsigned(8'h5A >> i)), 1'b0, r);
        wclk(4);
        sda_m = 1'b1;
        wclk(2);
        check("oe_in_wack", sda_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("oe_async_rst", sda_oe, 0);
        check("busy_async_rst", busy, 0);
        check("byte_cnt_async_rst", byte_cnt, 0);
        scl = 1'b1;
        wclk(4);
        rst = 1'b0;
        wclk(8);
        txn(ADDR, 1'b0, 1, 1'b1, 8'h77, 8'h00);

        // SDA glitches while SCL is low: idle bus, then inside a data byte
        scl = 1'b0;
        wclk(4);
        for (int g = 0; g < 3; g++) begin
            sda_m = ~sda_m;
            wclk(1);
        end
        wclk(2);
        sda_m = 1'b1;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        check("idle_glitch_starts", starts, exp_starts);
        check("idle_glitch_stops", stops, exp_stops);
        check("idle_glitch_busy", busy, 0);
        start_cond();
        send_byte({ADDR, 1'b0}, 1'b0, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b1, 1'b1);
        check("glitch_byte_cnt", byte_cnt, 1);
        stop_cond();
        check("glitch_starts", starts, exp_starts);
        check("glitch_stops", stops, exp_stops);

        for (int k = 0; k < 12; k++) begin
            a = ($urandom % 2 == 0) ? ADDR : 7'($urandom_range(0, 127));
            txn(a, 1'($urandom % 2), $urandom_range(1, 3), (k == 11) || ($urandom % 2 == 0),
                8'($urandom), 8'($urandom));
        end

        txn(ADDR, 1'b0, 257, 1'b1, 8'h01, 8'h02);

        wclk(8);
        check("rx_pending", exp_rx.size(), 0);
        check("rd_src_pending", rd_src.size(), 0);
        check("rd_req_total", rdreqs, exp_rdreqs);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
